ysyx_201979054_csr_unit: RTL

- Next-generation machine-mode CSR unit. Replaces the flat 8-entry CSR array with full 12-bit CSR address decode, CSRRW/CSRRS/CSRRC read-modify-write and illegal-access detection.
- Adds hardware trap entry/MRET sequencing, prioritised interrupt selection with vector computation, and optional 64-bit performance counters.
- Sits beside the decode/execute stage; the control FSM drives the trap/mret strobes.

---
 rtl/ysyx_201979054_csr_pkg.sv | 41 ++++
 rtl/ysyx_201979054_csr_counter.sv | 33 +++
 rtl/ysyx_201979054_csr_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_201979054_csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encoding,
// cause codes and mstatus/mip bit positions.
package ysyx_201979054_csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_t;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam logic [3:0] IRQ_CODE_MSI      = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI      = 4'd7;
    localparam logic [3:0] IRQ_CODE_MEI      = 4'd11;
    localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'd2;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

    localparam int MIP_MSIP_BIT = 3;
    localparam int MIP_MTIP_BIT = 7;
    localparam int MIP_MEIP_BIT = 11;

endpackage

// File: rtl/ysyx_201979054_csr_counter.sv
// 64-bit free-running counter with per-half write enables; a write to either
// half suppresses the increment for that cycle.
module ysyx_201979054_csr_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_we_lo || i_we_hi) begin
            if (i_we_lo) count_d[31:0]  = i_wdata[31:0];
            if (i_we_hi) count_d[63:32] = i_wdata[63:32];
        end else if (i_inc) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign o_count = count_q;

endmodule

// File: rtl/ysyx_201979054_csr_unit.sv
// Machine-mode CSR unit: address decode, read-modify-write, trap/MRET and
// interrupt selection. Define CSR_COUNTERS_EN to add mcycle/minstret.
module ysyx_201979054_csr_unit
    import ysyx_201979054_csr_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] HART_ID     = '0,
    parameter logic [DATA_WIDTH-1:0] MTVEC_RESET = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [11:0]           i_csr_addr,
    input  logic [1:0]            i_csr_op,
    input  logic [DATA_WIDTH-1:0] i_csr_wdata,
    output logic [DATA_WIDTH-1:0] o_csr_rdata,
    output logic                  o_illegal,
    input  logic                  i_trap,
    input  logic [3:0]            i_trap_cause,
    input  logic                  i_irq_take,
    input  logic [DATA_WIDTH-1:0] i_trap_pc,
    input  logic [DATA_WIDTH-1:0] i_trap_tval,
    input  logic                  i_mret,
    input  logic                  i_instr_retire,
    input  logic                  i_mtip,
    input  logic                  i_msip,
    input  logic                  i_meip,
    output logic                  o_irq_pending,
    output logic [3:0]            o_irq_cause,
    output logic [DATA_WIDTH-1:0] o_trap_vector,
    output logic [DATA_WIDTH-1:0] o_mepc
);

    localparam logic [1:0] MXL = (DATA_WIDTH == 64) ? 2'd2 : 2'd1;
    localparam logic [DATA_WIDTH-1:0] MISA_VAL =
        {MXL, {(DATA_WIDTH-2){1'b0}}} | (DATA_WIDTH'(1) << 8);
    localparam logic [DATA_WIDTH-1:0] IRQ_MASK =
        (DATA_WIDTH'(1) << MIP_MSIP_BIT) |
        (DATA_WIDTH'(1) << MIP_MTIP_BIT) |
        (DATA_WIDTH'(1) << MIP_MEIP_BIT);
    localparam logic [DATA_WIDTH-1:0] MTVEC_INIT =
        {MTVEC_RESET[DATA_WIDTH-1:2], 1'b0, MTVEC_RESET[0]};

    logic                  mstatus_mie_q, mstatus_mie_d;
    logic                  mstatus_mpie_q, mstatus_mpie_d;
    logic [DATA_WIDTH-1:0] mie_q, mie_d;
    logic [DATA_WIDTH-1:0] mip_q, mip_d;
    logic [DATA_WIDTH-1:0] mtvec_q, mtvec_d;
    logic [DATA_WIDTH-1:0] mscratch_q, mscratch_d;
    logic [DATA_WIDTH-1:0] mepc_q, mepc_d;
    logic [DATA_WIDTH-1:0] mcause_q, mcause_d;
    logic [DATA_WIDTH-1:0] mtval_q, mtval_d;

    csr_op_t               op;
    logic [DATA_WIDTH-1:0] mstatus_val;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [DATA_WIDTH-1:0] wr_val;
    logic                  addr_hit;
    logic                  wants_write;
    logic                  csr_we;
    logic [DATA_WIDTH-1:0] irq_active;
    logic [3:0]            irq_cause;
    logic                  irq_pending;
    logic                  irq_take_ok;
    logic [DATA_WIDTH-1:0] vec_base;

    assign op = csr_op_t'(i_csr_op);

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [63:0] cnt_wdata;
    logic        cyc_we_lo, cyc_we_hi, ret_we_lo, ret_we_hi;

    // On a 32-bit hart the operand is replicated so either half can take it.
    always_comb begin
        cnt_wdata = 64'(wr_val);
        if (DATA_WIDTH == 32) cnt_wdata = cnt_wdata | (64'(wr_val) << 32);
    end

    assign cyc_we_lo = csr_we && (i_csr_addr == CSR_MCYCLE);
    assign cyc_we_hi = csr_we && (i_csr_addr == ((DATA_WIDTH == 64) ? CSR_MCYCLE : CSR_MCYCLEH));
    assign ret_we_lo = csr_we && (i_csr_addr == CSR_MINSTRET);
    assign ret_we_hi = csr_we && (i_csr_addr == ((DATA_WIDTH == 64) ? CSR_MINSTRET : CSR_MINSTRETH));

    ysyx_201979054_csr_counter u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (1'b1),
        .i_we_lo (cyc_we_lo),
        .i_we_hi (cyc_we_hi),
        .i_wdata (cnt_wdata),
        .o_count (mcycle)
    );

    ysyx_201979054_csr_counter u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (i_instr_retire),
        .i_we_lo (ret_we_lo),
        .i_we_hi (ret_we_hi),
        .i_wdata (cnt_wdata),
        .o_count (minstret)
    );
`else
    logic unused_retire;
    assign unused_retire = i_instr_retire;
`endif

    always_comb begin
        mstatus_val = '0;
        mstatus_val[MSTATUS_MIE_BIT]                = mstatus_mie_q;
        mstatus_val[MSTATUS_MPIE_BIT]               = mstatus_mpie_q;
        mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    end

    always_comb begin
        addr_hit = 1'b1;
        rd_val   = '0;
        case (i_csr_addr)
            CSR_MSTATUS:  rd_val = mstatus_val;
            CSR_MISA:     rd_val = MISA_VAL;
            CSR_MIE:      rd_val = mie_q;
            CSR_MTVEC:    rd_val = mtvec_q;
            CSR_MSCRATCH: rd_val = mscratch_q;
            CSR_MEPC:     rd_val = mepc_q;
            CSR_MCAUSE:   rd_val = mcause_q;
            CSR_MTVAL:    rd_val = mtval_q;
            CSR_MIP:      rd_val = mip_q;
            CSR_MHARTID:  rd_val = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:   rd_val = DATA_WIDTH'(mcycle);
            CSR_MINSTRET: rd_val = DATA_WIDTH'(minstret);
            CSR_MCYCLEH: begin
                addr_hit = (DATA_WIDTH == 32);
                if (addr_hit) rd_val = DATA_WIDTH'(mcycle >> 32);
            end
            CSR_MINSTRETH: begin
                addr_hit = (DATA_WIDTH == 32);
                if (addr_hit) rd_val = DATA_WIDTH'(minstret >> 32);
            end
`endif
            default:      addr_hit = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            CSR_OP_RW: wr_val = i_csr_wdata;
            CSR_OP_RS: wr_val = rd_val | i_csr_wdata;
            CSR_OP_RC: wr_val = rd_val & ~i_csr_wdata;
            default:   wr_val = rd_val;
        endcase
    end

    // Set/clear with a zero operand is a pure read, so it is legal on read-only CSRs.
    assign wants_write = (op == CSR_OP_RW) ||
                         ((op != CSR_OP_NONE) && (i_csr_wdata != '0));
    assign o_illegal   = (op != CSR_OP_NONE) &&
                         (!addr_hit || ((i_csr_addr[11:10] == 2'b11) && wants_write));

    assign irq_active  = mie_q & mip_q;
    assign irq_pending = mstatus_mie_q && (irq_active != '0);
    assign irq_take_ok = i_irq_take && irq_pending;

    always_comb begin
        if (irq_active[MIP_MEIP_BIT])      irq_cause = IRQ_CODE_MEI;
        else if (irq_active[MIP_MSIP_BIT]) irq_cause = IRQ_CODE_MSI;
        else if (irq_active[MIP_MTIP_BIT]) irq_cause = IRQ_CODE_MTI;
        else                               irq_cause = 4'd0;
    end

    assign csr_we = wants_write && !o_illegal && !irq_take_ok && !i_trap && !i_mret;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mip_d          = '0;
        mip_d[MIP_MSIP_BIT] = i_msip;
        mip_d[MIP_MTIP_BIT] = i_mtip;
        mip_d[MIP_MEIP_BIT] = i_meip;

        if (irq_take_ok || i_trap) begin
            mepc_d         = {i_trap_pc[DATA_WIDTH-1:2], 2'b00};
            mcause_d       = irq_take_ok ? {1'b1, {(DATA_WIDTH-5){1'b0}}, irq_cause}
                                         : {1'b0, {(DATA_WIDTH-5){1'b0}}, i_trap_cause};
            mtval_d        = irq_take_ok ? '0 : i_trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (i_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (i_csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wr_val[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = wr_val[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_d      = wr_val & IRQ_MASK;
                CSR_MTVEC:    mtvec_d    = {wr_val[DATA_WIDTH-1:2], 1'b0, wr_val[0]};
                CSR_MSCRATCH: mscratch_d = wr_val;
                CSR_MEPC:     mepc_d     = {wr_val[DATA_WIDTH-1:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = wr_val;
                CSR_MTVAL:    mtval_d    = wr_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= MTVEC_INIT;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= mip_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    // Vectored offset only when the trap being vectored is the interrupt, not a
    // synchronous exception raised while an interrupt happens to be pending.
    assign vec_base = {mtvec_q[DATA_WIDTH-1:2], 2'b00};
    always_comb begin
        o_trap_vector = vec_base;
        if (mtvec_q[0] && irq_pending && (i_irq_take || !i_trap))
            o_trap_vector = vec_base + DATA_WIDTH'({irq_cause, 2'b00});
    end

    assign o_csr_rdata   = rd_val;
    assign o_irq_pending = irq_pending;
    assign o_irq_cause   = irq_cause;
    assign o_mepc        = mepc_q;

endmodule
